// File: rtl/cmsdk_apb_master_arbiter.sv
// Two-requester APB master with round-robin arbitration.
// Each requester posts one transfer at a time; the arbiter runs it through
// the APB SETUP/ACCESS phases and returns a one-cycle completion pulse with
// read data and error status.
// Optional feature macro: APB_ARB_TIMEOUT_EN. When defined, ACCESS is
// abandoned after TIMEOUT_CYCLES wait states and the transfer completes
// with an error.
module cmsdk_apb_master_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        REQ0_VALID,
    output logic        REQ0_READY,
    input  logic [15:0] REQ0_ADDR,
    input  logic        REQ0_WRITE,
    input  logic [31:0] REQ0_WDATA,
    input  logic        REQ1_VALID,
    output logic        REQ1_READY,
    input  logic [15:0] REQ1_ADDR,
    input  logic        REQ1_WRITE,
    input  logic [31:0] REQ1_WDATA,
    output logic        RSP0_VALID,
    output logic [31:0] RSP0_RDATA,
    output logic        RSP0_ERR,
    output logic        RSP1_VALID,
    output logic [31:0] RSP1_RDATA,
    output logic        RSP1_ERR,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [15:0] PADDR,
    output logic [31:0] PWDATA,
    output logic [3:0]  DECODE4BIT,
    input  logic        PREADY,
    input  logic [31:0] PRDATA,
    input  logic        PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        grant_vld;
    logic        grant_sel;   // 0 = requester 0, 1 = requester 1
    logic        gid;         // requester owning the in-flight transfer
    logic        rr_last;     // requester granted most recently
    logic        done;        // transfer finishes this cycle
    logic        tmo;         // wait-state limit reached this cycle
    logic [31:0] rsp_rdata;
    logic        rsp_err;

`ifdef APB_ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    assign tmo = (state == ACCESS) && !PREADY &&
                 (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));

    // Count ACCESS wait states; restart for every new transfer in SETUP.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tmo_cnt <= 8'd0;
        end else if (state == SETUP) begin
            tmo_cnt <= 8'd0;
        end else if (state == ACCESS && !PREADY) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end
`else
    // Without the timeout, ACCESS waits for PREADY forever.
    logic [7:0] unused_tmo_cycles;
    assign unused_tmo_cycles = 8'(TIMEOUT_CYCLES);
    assign tmo = 1'b0;
`endif

    // Next state, arbitration and completion detection.
    always_comb begin
        state_nxt = state;
        grant_vld = 1'b0;
        grant_sel = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (REQ0_VALID || REQ1_VALID) begin
                    grant_vld = 1'b1;
                    // Contended: alternate; otherwise serve whoever asks.
                    grant_sel = (REQ0_VALID && REQ1_VALID) ? ~rr_last : REQ1_VALID;
                    state_nxt = SETUP;
                end
            end
            SETUP: state_nxt = ACCESS;
            ACCESS: begin
                if (PREADY || tmo) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A grant is not acknowledged while reset is about to discard it.
    assign REQ0_READY = grant_vld && !grant_sel && !PRESET;
    assign REQ1_READY = grant_vld &&  grant_sel && !PRESET;

    assign PSEL       = (state != IDLE);
    assign PENABLE    = (state == ACCESS);
    assign DECODE4BIT = PADDR[15:12];

    // Completion payload: writes and timeouts return zero data.
    assign rsp_rdata = (PWRITE || tmo) ? 32'd0 : PRDATA;
    assign rsp_err   = tmo ? 1'b1 : PSLVERR;

    // FSM state register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture granted request, hold APB payload, produce completion responses.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rr_last    <= 1'b1;   // first contended grant goes to requester 0
            gid        <= 1'b0;
            PADDR      <= 16'd0;
            PWRITE     <= 1'b0;
            PWDATA     <= 32'd0;
            RSP0_VALID <= 1'b0;
            RSP1_VALID <= 1'b0;
            RSP0_RDATA <= 32'd0;
            RSP1_RDATA <= 32'd0;
            RSP0_ERR   <= 1'b0;
            RSP1_ERR   <= 1'b0;
        end else begin
            if (grant_vld) begin
                rr_last <= grant_sel;
                gid     <= grant_sel;
                if (grant_sel) begin
                    PADDR  <= REQ1_ADDR;
                    PWRITE <= REQ1_WRITE;
                    PWDATA <= REQ1_WRITE ? REQ1_WDATA : 32'd0;
                end else begin
                    PADDR  <= REQ0_ADDR;
                    PWRITE <= REQ0_WRITE;
                    PWDATA <= REQ0_WRITE ? REQ0_WDATA : 32'd0;
                end
            end
            RSP0_VALID <= done && !gid;
            RSP1_VALID <= done &&  gid;
            if (done && !gid) begin
                RSP0_RDATA <= rsp_rdata;
                RSP0_ERR   <= rsp_err;
            end
            if (done && gid) begin
                RSP1_RDATA <= rsp_rdata;
                RSP1_ERR   <= rsp_err;
            end
        end
    end

endmodule

// File: tb/tb_cmsdk_apb_master_arbiter.sv
// Directed bench for cmsdk_apb_master_arbiter: cycle-by-cycle vector table
// plus hand-written reset-abort and long-wait sequences.
module tb_cmsdk_apb_master_arbiter;

    localparam logic [15:0] A0 = 16'h3004;
    localparam logic [15:0] A1 = 16'hF010;
    localparam logic [31:0] W0 = 32'hAAAA5555;
    localparam logic [31:0] W1 = 32'h12345678;
    localparam logic [31:0] D1 = 32'hDEADBEEF;
    localparam logic [31:0] D2 = 32'hCAFEF00D;
    localparam logic [31:0] Z  = 32'h0;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        REQ0_VALID, REQ1_VALID;
    logic        REQ0_READY, REQ1_READY;
    logic [15:0] REQ0_ADDR, REQ1_ADDR;
    logic        REQ0_WRITE, REQ1_WRITE;
    logic [31:0] REQ0_WDATA, REQ1_WDATA;
    logic        RSP0_VALID, RSP1_VALID;
    logic [31:0] RSP0_RDATA, RSP1_RDATA;
    logic        RSP0_ERR, RSP1_ERR;
    logic        PSEL, PENABLE, PWRITE;
    logic [15:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  DECODE4BIT;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    int checks = 0;
    int errors = 0;

    cmsdk_apb_master_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_ADDR(REQ0_ADDR),
        .REQ0_WRITE(REQ0_WRITE), .REQ0_WDATA(REQ0_WDATA),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_ADDR(REQ1_ADDR),
        .REQ1_WRITE(REQ1_WRITE), .REQ1_WDATA(REQ1_WDATA),
        .RSP0_VALID(RSP0_VALID), .RSP0_RDATA(RSP0_RDATA), .RSP0_ERR(RSP0_ERR),
        .RSP1_VALID(RSP1_VALID), .RSP1_RDATA(RSP1_RDATA), .RSP1_ERR(RSP1_ERR),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .DECODE4BIT(DECODE4BIT),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [2:0]  in_ctl;   // {REQ0_VALID, REQ1_VALID, PREADY}
        logic [31:0] prdata;
        logic        slverr;
        logic [3:0]  o_ctl;    // {REQ0_READY, REQ1_READY, PSEL, PENABLE}
        logic [15:0] paddr;
        logic [31:0] pwdata;
        logic        pwrite;
        logic [1:0]  rsp;      // {RSP0_VALID, RSP1_VALID}
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [1:0]  err;      // {RSP0_ERR, RSP1_ERR}
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(input logic [2:0] in_ctl, input logic [31:0] prdata,
                                input logic slverr, input logic [3:0] o_ctl,
                                input logic [15:0] paddr, input logic [31:0] pwdata,
                                input logic pwrite, input logic [1:0] rsp,
                                input logic [31:0] rd0, input logic [31:0] rd1,
                                input logic [1:0] err);
        vec_t v;
        v.in_ctl = in_ctl; v.prdata = prdata; v.slverr = slverr; v.o_ctl = o_ctl;
        v.paddr = paddr; v.pwdata = pwdata; v.pwrite = pwrite; v.rsp = rsp;
        v.rd0 = rd0; v.rd1 = rd1; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic settle();
        #7;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready0"}, 32'(REQ0_READY), Z);
        chk({tag, "_ready1"}, 32'(REQ1_READY), Z);
        chk({tag, "_psel"},   32'(PSEL), Z);
        chk({tag, "_penable"},32'(PENABLE), Z);
        chk({tag, "_pwrite"}, 32'(PWRITE), Z);
        chk({tag, "_paddr"},  32'(PADDR), Z);
        chk({tag, "_pwdata"}, PWDATA, Z);
        chk({tag, "_decode"}, 32'(DECODE4BIT), Z);
        chk({tag, "_rsp0"},   32'(RSP0_VALID), Z);
        chk({tag, "_rsp1"},   32'(RSP1_VALID), Z);
        chk({tag, "_rdata0"}, RSP0_RDATA, Z);
        chk({tag, "_rdata1"}, RSP1_RDATA, Z);
        chk({tag, "_err0"},   32'(RSP0_ERR), Z);
        chk({tag, "_err1"},   32'(RSP1_ERR), Z);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESET = 1'b1;
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        REQ0_ADDR = A0; REQ0_WRITE = 1'b0; REQ0_WDATA = W0;
        REQ1_ADDR = A1; REQ1_WRITE = 1'b1; REQ1_WDATA = W1;
        PREADY = 1'b0; PRDATA = Z; PSLVERR = 1'b0;

        // Row n: inputs during cycle n and outputs expected in that cycle.
        tbl[0]  = mk(3'b100, Z, 1'b0, 4'b1000, 16'h0, Z,  1'b0, 2'b00, Z,  Z, 2'b00);
        tbl[1]  = mk(3'b000, Z, 1'b0, 4'b0010, A0,    Z,  1'b0, 2'b00, Z,  Z, 2'b00);
        tbl[2]  = mk(3'b001, D1, 1'b0, 4'b0011, A0,   Z,  1'b0, 2'b00, Z,  Z, 2'b00);
        tbl[3]  = mk(3'b110, Z, 1'b0, 4'b0100, A0,    Z,  1'b0, 2'b10, D1, Z, 2'b00);
        tbl[4]  = mk(3'b110, Z, 1'b0, 4'b0010, A1,    W1, 1'b1, 2'b00, D1, Z, 2'b00);
        tbl[5]  = mk(3'b111, 32'h55, 1'b0, 4'b0011, A1, W1, 1'b1, 2'b00, D1, Z, 2'b00);
        tbl[6]  = mk(3'b110, Z, 1'b0, 4'b1000, A1,    W1, 1'b1, 2'b01, D1, Z, 2'b00);
        tbl[7]  = mk(3'b110, Z, 1'b0, 4'b0010, A0,    Z,  1'b0, 2'b00, D1, Z, 2'b00);
        tbl[8]  = mk(3'b111, D2, 1'b1, 4'b0011, A0,   Z,  1'b0, 2'b00, D1, Z, 2'b00);
        tbl[9]  = mk(3'b110, Z, 1'b0, 4'b0100, A0,    Z,  1'b0, 2'b10, D2, Z, 2'b10);
        tbl[10] = mk(3'b000, Z, 1'b0, 4'b0010, A1,    W1, 1'b1, 2'b00, D2, Z, 2'b10);
        tbl[11] = mk(3'b000, Z, 1'b0, 4'b0011, A1,    W1, 1'b1, 2'b00, D2, Z, 2'b10);
        tbl[12] = mk(3'b000, Z, 1'b0, 4'b0011, A1,    W1, 1'b1, 2'b00, D2, Z, 2'b10);
        tbl[13] = mk(3'b000, Z, 1'b0, 4'b0011, A1,    W1, 1'b1, 2'b00, D2, Z, 2'b10);
        tbl[14] = mk(3'b001, 32'hFFFFFFFF, 1'b1, 4'b0011, A1, W1, 1'b1, 2'b00, D2, Z, 2'b10);
        tbl[15] = mk(3'b000, Z, 1'b0, 4'b0000, A1,    W1, 1'b1, 2'b01, D2, Z, 2'b11);
        tbl[16] = mk(3'b000, Z, 1'b0, 4'b0000, A1,    W1, 1'b1, 2'b00, D2, Z, 2'b11);

        // Reset state
        tick(); tick();
        settle();
        chk_all_zero("reset");

        // Vector table: read, alternating contention, write with wait states
        for (int i = 0; i < 17; i++) begin
            tick();
            PRESET = 1'b0;
            REQ0_VALID = tbl[i].in_ctl[2];
            REQ1_VALID = tbl[i].in_ctl[1];
            PREADY     = tbl[i].in_ctl[0];
            PRDATA     = tbl[i].prdata;
            PSLVERR    = tbl[i].slverr;
            settle();
            chk($sformatf("v%0d_ready0", i),  32'(REQ0_READY), 32'(tbl[i].o_ctl[3]));
            chk($sformatf("v%0d_ready1", i),  32'(REQ1_READY), 32'(tbl[i].o_ctl[2]));
            chk($sformatf("v%0d_psel", i),    32'(PSEL),       32'(tbl[i].o_ctl[1]));
            chk($sformatf("v%0d_penable", i), 32'(PENABLE),    32'(tbl[i].o_ctl[0]));
            chk($sformatf("v%0d_paddr", i),   32'(PADDR),      32'(tbl[i].paddr));
            chk($sformatf("v%0d_decode", i),  32'(DECODE4BIT), 32'(tbl[i].paddr[15:12]));
            chk($sformatf("v%0d_pwdata", i),  PWDATA,          tbl[i].pwdata);
            chk($sformatf("v%0d_pwrite", i),  32'(PWRITE),     32'(tbl[i].pwrite));
            chk($sformatf("v%0d_rsp0", i),    32'(RSP0_VALID), 32'(tbl[i].rsp[1]));
            chk($sformatf("v%0d_rsp1", i),    32'(RSP1_VALID), 32'(tbl[i].rsp[0]));
            chk($sformatf("v%0d_rdata0", i),  RSP0_RDATA,      tbl[i].rd0);
            chk($sformatf("v%0d_rdata1", i),  RSP1_RDATA,      tbl[i].rd1);
            chk($sformatf("v%0d_err0", i),    32'(RSP0_ERR),   32'(tbl[i].err[1]));
            chk($sformatf("v%0d_err1", i),    32'(RSP1_ERR),   32'(tbl[i].err[0]));
        end

        // Reset during ACCESS aborts the transfer without a response
        tick(); REQ0_VALID = 1'b1; settle();
        chk("abort_grant", 32'(REQ0_READY), 32'd1);
        tick(); REQ0_VALID = 1'b0; settle();
        chk("abort_setup", 32'({PSEL, PENABLE}), 32'b10);
        tick(); PREADY = 1'b0; settle();
        chk("abort_access", 32'({PSEL, PENABLE}), 32'b11);
        tick(); PRESET = 1'b1; PREADY = 1'b1; PRDATA = 32'h11111111; settle();
        tick(); PRESET = 1'b0; PREADY = 1'b0; PRDATA = Z; settle();
        chk_all_zero("abort_after");
        tick(); settle();
        chk("abort_norsp0", 32'(RSP0_VALID), Z);
        chk("abort_idle", 32'(PSEL), Z);

        // First contended grant after reset goes to requester 0
        tick(); REQ0_VALID = 1'b1; REQ1_VALID = 1'b1; settle();
        chk("post_rst_ready0", 32'(REQ0_READY), 32'd1);
        chk("post_rst_ready1", 32'(REQ1_READY), Z);
        tick(); REQ0_VALID = 1'b0; REQ1_VALID = 1'b0; settle();
        chk("post_rst_paddr", 32'(PADDR), 32'(A0));
        chk("post_rst_setup", 32'({PSEL, PENABLE}), 32'b10);
        tick(); PREADY = 1'b1; PRDATA = 32'h0BADF00D; settle();
        chk("post_rst_access", 32'({PSEL, PENABLE}), 32'b11);
        tick(); PREADY = 1'b0; PRDATA = Z; settle();
        chk("post_rst_rsp0", 32'(RSP0_VALID), 32'd1);
        chk("post_rst_rsp1", 32'(RSP1_VALID), Z);
        chk("post_rst_rdata0", RSP0_RDATA, 32'h0BADF00D);
        chk("post_rst_err0", 32'(RSP0_ERR), Z);

        // Long wait: timeout when compiled in, indefinite hold otherwise
        tick(); REQ0_VALID = 1'b1; settle();
        tick(); REQ0_VALID = 1'b0; settle();
        chk("wait_setup", 32'({PSEL, PENABLE}), 32'b10);
`ifdef APB_ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            tick(); settle();
            chk($sformatf("tmo_access%0d", i), 32'({PSEL, PENABLE}), 32'b11);
            chk($sformatf("tmo_norsp%0d", i), 32'(RSP0_VALID), Z);
        end
        tick(); settle();
        chk("tmo_psel", 32'(PSEL), Z);
        chk("tmo_rsp0", 32'(RSP0_VALID), 32'd1);
        chk("tmo_err0", 32'(RSP0_ERR), 32'd1);
        chk("tmo_rdata0", RSP0_RDATA, Z);
`else
        for (int i = 0; i < 100; i++) begin
            tick(); settle();
            chk($sformatf("hold_access%0d", i), 32'({PSEL, PENABLE, RSP0_VALID}), 32'b110);
        end
        tick(); PREADY = 1'b1; PRDATA = 32'h13572468; settle();
        tick(); PREADY = 1'b0; PRDATA = Z; settle();
        chk("hold_rsp0", 32'(RSP0_VALID), 32'd1);
        chk("hold_rdata0", RSP0_RDATA, 32'h13572468);
        chk("hold_err0", 32'(RSP0_ERR), Z);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmsdk_apb_master_arbiter.md
CMSDK_APB_MASTER_ARBITER -- requirements
Module: cmsdk_apb_master_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: number of ACCESS cycles with PREADY low before timeout (range 1..255); used only when the timeout feature is compiled in.
REQ-002 PCLK  input  1  single clock; all state changes on rising edge.
REQ-003 PRESET  input  1  reset, synchronous, active-high.
REQ-004 REQ0_VALID / REQ1_VALID  input  1  requester n has a transfer pending.
REQ-005 REQ0_READY / REQ1_READY  output  1  one-cycle pulse: requester n's transfer accepted this cycle.
REQ-006 REQ0_ADDR / REQ1_ADDR  input  16  byte address; REQn_WRITE  input  1  1=write; REQn_WDATA  input  32  write data.
REQ-007 RSP0_VALID / RSP1_VALID  output  1  one-cycle completion pulse; RSPn_RDATA  output  32  read data; RSPn_ERR  output  1  transfer error.
REQ-008 PSEL, PENABLE, PWRITE  output  1  APB control; PADDR  output  16; PWDATA  output  32.
REQ-009 DECODE4BIT  output  4  equals PADDR[15:12]; drives the downstream APB slave multiplexer.
REQ-010 PREADY  input  1; PRDATA  input  32; PSLVERR  input  1  returned from the slave multiplexer.

Function
REQ-011 The FSM SHALL have states IDLE, SETUP, ACCESS; PSEL=0 in IDLE, PSEL=1/PENABLE=0 in SETUP, PSEL=1/PENABLE=1 in ACCESS.
REQ-012 In IDLE, if any REQn_VALID is high, the arbiter SHALL grant one requester, pulse its REQn_READY, register ADDR/WRITE/WDATA and the grant ID, and move to SETUP next cycle.
REQ-013 Arbitration SHALL be round-robin: when both request, grant the requester not granted last; a single requester is granted regardless of pointer.
REQ-014 The round-robin pointer SHALL update only on a grant.
REQ-015 SETUP SHALL last exactly one cycle, then ACCESS.
REQ-016 ACCESS SHALL hold until PREADY=1; PADDR, PWRITE, PWDATA SHALL remain stable from SETUP through the last ACCESS cycle.
REQ-017 On the ACCESS cycle with PREADY=1, the FSM SHALL return to IDLE, and in the following cycle RSPn_VALID of the granted requester SHALL pulse with RSPn_ERR=PSLVERR and RSPn_RDATA=PRDATA for reads, 0 for writes.
REQ-018 RSPn_RDATA/RSPn_ERR SHALL hold their value until the next completion for that requester.
REQ-019 Latency: grant at cycle N, SETUP N+1, ACCESS N+2, RSP_VALID at N+3 with zero wait states; each wait state adds one cycle; the next grant can occur no earlier than the RSP_VALID cycle.
REQ-020 PWDATA SHALL be 0 for read transfers; PADDR/DECODE4BIT SHALL hold the last address in IDLE.
REQ-021 REQn_VALID deassertion after acceptance SHALL NOT affect an in-flight transfer.

Reset
REQ-022 PRESET=1 at a clock edge SHALL force IDLE and zero every output (PSEL, PENABLE, PWRITE, PADDR, PWDATA, DECODE4BIT, REQn_READY, RSPn_VALID, RSPn_RDATA, RSPn_ERR), including mid-transfer, with no RSP pulse for the aborted transfer.
REQ-023 After reset, the round-robin pointer SHALL favour requester 0 on the first contended grant; the timeout counter SHALL be 0.

Configuration
REQ-024 Macro APB_ARB_TIMEOUT_EN defined: an 8-bit counter SHALL count ACCESS cycles with PREADY=0; on reaching TIMEOUT_CYCLES the FSM SHALL return to IDLE (PSEL/PENABLE low next cycle) and pulse RSPn_VALID with RSPn_ERR=1, RSPn_RDATA=0; counter clears on every SETUP.
REQ-025 Macro undefined: no counter SHALL exist; ACCESS waits for PREADY indefinitely; TIMEOUT_CYCLES is ignored.

Verification
REQ-026 Reset then REQ0 read 0x3004, PREADY=1, PRDATA=0xDEADBEEF -> READY0 at N, SETUP N+1, ACCESS N+2, RSP0_VALID N+3 with RDATA=0xDEADBEEF, ERR=0, DECODE4BIT=3.
REQ-027 Both requesters valid continuously, 4 transfers -> grant order 0,1,0,1; each RSP only to its own requester.
REQ-028 REQ1 write 0xF010 data 0x12345678, PREADY low 3 ACCESS cycles, PSLVERR=1 -> PADDR/PWDATA stable for 4 ACCESS cycles, RSP1_VALID with ERR=1, RDATA=0.
REQ-029 PRESET asserted during ACCESS -> next cycle all outputs 0, state IDLE, no RSP pulse; subsequent request completes normally.
REQ-030 With APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY held 0 -> PSEL drops after 4 ACCESS cycles, RSP0_VALID with ERR=1; without the macro PSEL stays high for 100 cycles.
